// File: rtl/wdata_arb_mux.sv
// ---------------------------------------------------------------------------
// wdata_arb_mux
//
// Write-data multiplexer that sits between several master write ports and a
// single slave-side write-data bus. When a transfer starts, the one-hot
// arbiter grant is captured. That master stays selected for the whole burst.
// Each beat passes through one output register that uses a valid/ready
// handshake. The final beat of the burst is marked with s_wlast.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   grant      one-hot grant from the arbiter, sampled only on start
//   start      single-cycle pulse that begins a transfer for grant
//   burst_len  number of beats minus one (0 = single beat)
//   m_wdata    packed master data, master i at [i*DATA_W +: DATA_W]
//   m_wvalid   per-master beat valid
//   m_wready   per-master beat accept (only the selected master can see 1)
//   s_wdata    registered slave-side write data
//   s_wvalid   registered slave-side beat valid
//   s_wlast    final beat of the burst, qualified by s_wvalid
//   s_wready   slave accepts the beat held in the output register
//   busy       a transfer is in progress
//   err        single-cycle pulse when start arrives with a zero or
//              multi-hot grant
// ---------------------------------------------------------------------------
module wdata_arb_mux #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_W      = 32,
    parameter int BURST_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        grant,
    input  logic                          start,
    input  logic [BURST_W-1:0]            burst_len,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]        m_wvalid,
    output logic [NUM_MASTERS-1:0]        m_wready,
    output logic [DATA_W-1:0]             s_wdata,
    output logic                          s_wvalid,
    output logic                          s_wlast,
    input  logic                          s_wready,
    output logic                          busy,
    output logic                          err
);

    localparam int SEL_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] XFER  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [BURST_W:0] CNT_ONE = 1;

    logic [1:0]         state;
    logic [SEL_W-1:0]   sel;
    logic [BURST_W-1:0] len;
    logic [BURST_W:0]   acc_cnt;

    logic [SEL_W-1:0]   grant_idx;
    logic               grant_ok;
    logic               sel_wvalid;
    logic [DATA_W-1:0]  sel_wdata;
    logic               out_free;
    logic               accept;
    logic               beat_last;

    // Encode the one-hot grant into a master index. The result is only used
    // when the grant has been confirmed to be one-hot.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                grant_idx = SEL_W'(i);
            end
        end
        grant_ok = $onehot(grant);
    end

    // Path from the selected master. The output register can accept a new
    // beat when it is empty or when it is being drained in this same cycle.
    // This allows one beat per cycle while s_wready stays high.
    // acc_cnt is one bit wider than len. This lets a maximum-length burst
    // reach its last compare without the counter wrapping.
    always_comb begin
        sel_wvalid = m_wvalid[sel];
        sel_wdata  = m_wdata[int'(sel) * DATA_W +: DATA_W];
        out_free   = !s_wvalid || s_wready;
        accept     = (state == XFER) && sel_wvalid && out_free;
        beat_last  = (acc_cnt == {1'b0, len});
    end

    // Only the latched master is offered ready, and only while beats are
    // still being collected. During IDLE and DRAIN every master sees 0.
    always_comb begin
        m_wready = '0;
        if (state == XFER) begin
            m_wready[sel] = out_free;
        end
    end

    assign busy = (state != IDLE);

    // Transfer control and the output register. A start that arrives while
    // busy is ignored. A stalled output (valid high, ready low) holds its
    // contents because no accept can occur while m_wready is low. A reset
    // during a burst drops the partial burst and issues no last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            len      <= '0;
            acc_cnt  <= '0;
            s_wdata  <= '0;
            s_wvalid <= 1'b0;
            s_wlast  <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (grant_ok) begin
                            sel     <= grant_idx;
                            len     <= burst_len;
                            acc_cnt <= '0;
                            state   <= XFER;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (accept) begin
                        s_wdata  <= sel_wdata;
                        s_wvalid <= 1'b1;
                        s_wlast  <= beat_last;
                        acc_cnt  <= acc_cnt + CNT_ONE;
                        if (beat_last) begin
                            state <= DRAIN;
                        end
                    end else if (s_wready) begin
                        s_wvalid <= 1'b0;
                        s_wlast  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (s_wvalid && s_wready) begin
                        s_wvalid <= 1'b0;
                        s_wlast  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wdata_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_wdata_arb_mux
//
// Self-checking bench for wdata_arb_mux with two masters, 32-bit data and a
// 4-bit burst length. A transaction-level model runs alongside the DUT. It
// tracks whether a burst is active, which master owns it and how many beats
// it still needs. It also keeps a queue of beats accepted but not yet taken
// by the slave. On every falling edge the DUT outputs are compared with that
// model. Directed scenarios add literal expectations, and a random phase
// follows them.
// ---------------------------------------------------------------------------
module tb_wdata_arb_mux;

    localparam int NM = 2;
    localparam int DW = 32;
    localparam int BW = 4;

    logic             clk;
    logic             rst;
    logic [NM-1:0]    grant;
    logic             start;
    logic [BW-1:0]    burst_len;
    logic [NM*DW-1:0] m_wdata;
    logic [NM-1:0]    m_wvalid;
    logic [NM-1:0]    m_wready;
    logic [DW-1:0]    s_wdata;
    logic             s_wvalid;
    logic             s_wlast;
    logic             s_wready;
    logic             busy;
    logic             err;

    int total = 0;
    int bad   = 0;

    wdata_arb_mux #(
        .NUM_MASTERS(NM),
        .DATA_W     (DW),
        .BURST_W    (BW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .grant    (grant),
        .start    (start),
        .burst_len(burst_len),
        .m_wdata  (m_wdata),
        .m_wvalid (m_wvalid),
        .m_wready (m_wready),
        .s_wdata  (s_wdata),
        .s_wvalid (s_wvalid),
        .s_wlast  (s_wlast),
        .s_wready (s_wready),
        .busy     (busy),
        .err      (err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transaction-level model state. The queue holds the beats that have
    // been handed to the slave side and not yet consumed.
    typedef struct {
        logic [DW-1:0] data;
        bit            last;
    } beat_t;

    beat_t q[$];
    bit    model_live = 0;
    bit    m_busy     = 0;
    bit    m_drain    = 0;
    bit    m_err      = 0;
    int    m_sel      = 0;
    int    m_len      = 0;
    int    m_beat     = 0;

    logic [NM-1:0] mdl_rdy;
    bit            mdl_hs;
    bit            mdl_acc;
    bit            mdl_was_busy;

    int hs_cnt   = 0;
    int last_cnt = 0;
    int last_at  = 0;

    function automatic bit is_onehot(input logic [NM-1:0] g);
        int n = 0;
        for (int i = 0; i < NM; i++) begin
            if (g[i]) n++;
        end
        return n == 1;
    endfunction

    function automatic int onehot_idx(input logic [NM-1:0] g);
        int r = 0;
        for (int i = 0; i < NM; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    // The owning master may hand over a beat while beats are still owed
    // and the slave side can take one (the queue is empty or is being
    // popped this cycle).
    function automatic logic [NM-1:0] model_ready(input logic sw);
        logic [NM-1:0] r = '0;
        if (m_busy && !m_drain && (q.size() == 0 || sw)) begin
            r[m_sel] = 1'b1;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model at every rising edge using the inputs that are
    // settled just before the edge. All decisions use the state from before
    // the edge, so a start that arrives during a burst is ignored.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_busy     = 0;
            m_drain    = 0;
            m_err      = 0;
            m_sel      = 0;
            m_len      = 0;
            m_beat     = 0;
            model_live = 1;
        end else begin
            mdl_rdy      = model_ready(s_wready);
            mdl_hs       = (q.size() != 0) && s_wready;
            mdl_acc      = m_busy && !m_drain && m_wvalid[m_sel] && mdl_rdy[m_sel];
            mdl_was_busy = m_busy;
            m_err        = !mdl_was_busy && start && !is_onehot(grant);
            if (mdl_hs) begin
                void'(q.pop_front());
                if (m_drain) begin
                    m_busy  = 0;
                    m_drain = 0;
                end
            end
            if (mdl_acc) begin
                q.push_back('{m_wdata[m_sel*DW +: DW], (m_beat == m_len)});
                m_beat++;
                if (m_beat > m_len) m_drain = 1;
            end
            if (!mdl_was_busy && start && is_onehot(grant)) begin
                m_busy = 1;
                m_sel  = onehot_idx(grant);
                m_len  = int'(burst_len);
                m_beat = 0;
            end
        end
    end

    // Compare every output with the model on each falling edge. Slave-side
    // handshakes are also counted so that bursts can be checked as a whole.
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("busy", busy, m_busy);
            checkOutput("err", err, m_err);
            checkOutput("m_wready", m_wready, model_ready(s_wready));
            checkOutput("s_wvalid", s_wvalid, q.size() != 0);
            checkOutput("s_wlast", s_wlast, (q.size() != 0) ? q[0].last : 1'b0);
            if (q.size() != 0) begin
                checkOutput("s_wdata", s_wdata, q[0].data);
            end
            if (s_wvalid && s_wready) begin
                hs_cnt++;
                if (s_wlast) begin
                    last_cnt++;
                    last_at = hs_cnt;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NM-1:0] g, input logic st,
                                 input logic [BW-1:0] bl, input logic [NM-1:0] wv,
                                 input logic sr);
        grant     = g;
        start     = st;
        burst_len = bl;
        m_wvalid  = wv;
        s_wready  = sr;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        checkOutput("wait_idle", busy, 1'b0);
    endtask

    // Directed scenarios first, then a randomized phase.
    initial begin
        int base;
        rst     = 1'b1;
        m_wdata = '0;
        applyStimulus(2'b00, 1'b0, 4'd0, 2'b00, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wvalid", s_wvalid, 1'b0);
        checkOutput("rst_wdata", s_wdata, 32'h0);

        // Single beat from master 1.
        m_wdata = {32'hDEADBEEF, 32'h11111111};
        applyStimulus(2'b10, 1'b1, 4'd0, 2'b10, 1'b0);
        tick();
        applyStimulus(2'b00, 1'b0, 4'd0, 2'b10, 1'b0);
        checkOutput("t2_ready", m_wready, 2'b10);
        tick();
        checkOutput("t2_wdata", s_wdata, 32'hDEADBEEF);
        checkOutput("t2_wvalid", s_wvalid, 1'b1);
        checkOutput("t2_wlast", s_wlast, 1'b1);
        checkOutput("t2_drain_rdy", m_wready, 2'b00);
        applyStimulus(2'b00, 1'b0, 4'd0, 2'b00, 1'b1);
        tick();
        checkOutput("t2_busy_low", busy, 1'b0);
        checkOutput("t2_wvalid_low", s_wvalid, 1'b0);

        // Four-beat burst from master 0 at full throughput.
        applyStimulus(2'b01, 1'b1, 4'd3, 2'b00, 1'b1);
        tick();
        for (int b = 1; b <= 4; b++) begin
            m_wdata = {32'hCAFE0000 + 32'(b), 32'(b)};
            applyStimulus(2'b10, 1'b0, 4'd0, 2'b11, 1'b1);
            tick();
            checkOutput("t3_wdata", s_wdata, 32'(b));
            checkOutput("t3_wlast", s_wlast, b == 4);
            checkOutput("t3_rdy1", m_wready[1], 1'b0);
        end
        applyStimulus(2'b00, 1'b0, 4'd0, 2'b00, 1'b1);
        wait_idle(10);

        // The same burst with a three-cycle stall while beat 2 is held.
        base = hs_cnt;
        applyStimulus(2'b01, 1'b1, 4'd3, 2'b00, 1'b1);
        tick();
        for (int b = 1; b <= 2; b++) begin
            m_wdata[31:0] = 32'(b);
            applyStimulus(2'b00, 1'b0, 4'd0, 2'b01, 1'b1);
            tick();
        end
        m_wdata[31:0] = 32'd3;
        for (int s = 0; s < 3; s++) begin
            applyStimulus(2'b00, 1'b0, 4'd0, 2'b01, 1'b0);
            tick();
            checkOutput("t4_hold", s_wdata, 32'd2);
            checkOutput("t4_stall_rdy", m_wready, 2'b00);
        end
        applyStimulus(2'b00, 1'b0, 4'd0, 2'b01, 1'b1);
        tick();
        checkOutput("t4_beat3", s_wdata, 32'd3);
        m_wdata[31:0] = 32'd4;
        tick();
        checkOutput("t4_beat4", s_wdata, 32'd4);
        applyStimulus(2'b00, 1'b0, 4'd0, 2'b00, 1'b1);
        wait_idle(10);
        checkOutput("t4_beats", hs_cnt - base, 4);

        // A bad grant produces an err pulse. A start during busy is ignored.
        applyStimulus(2'b11, 1'b1, 4'd0, 2'b00, 1'b0);
        tick();
        checkOutput("t5_err_11", err, 1'b1);
        checkOutput("t5_busy_11", busy, 1'b0);
        applyStimulus(2'b00, 1'b0, 4'd0, 2'b00, 1'b0);
        tick();
        checkOutput("t5_err_clr", err, 1'b0);
        applyStimulus(2'b00, 1'b1, 4'd0, 2'b00, 1'b0);
        tick();
        checkOutput("t5_err_00", err, 1'b1);
        checkOutput("t5_busy_00", busy, 1'b0);
        applyStimulus(2'b01, 1'b1, 4'd1, 2'b00, 1'b0);
        tick();
        applyStimulus(2'b11, 1'b1, 4'd0, 2'b00, 1'b0);
        tick();
        checkOutput("t5_busy_err", err, 1'b0);
        applyStimulus(2'b10, 1'b1, 4'd0, 2'b00, 1'b0);
        tick();
        checkOutput("t5_busy_keep", m_wready, 2'b01);
        applyStimulus(2'b00, 1'b0, 4'd0, 2'b01, 1'b1);
        tick();
        tick();
        applyStimulus(2'b00, 1'b0, 4'd0, 2'b00, 1'b1);
        wait_idle(10);

        // Maximum burst of 16 beats, then master 1 starts right away.
        base = hs_cnt;
        applyStimulus(2'b01, 1'b1, 4'hF, 2'b00, 1'b1);
        tick();
        for (int b = 1; b <= 16; b++) begin
            m_wdata[31:0] = 32'h100 + 32'(b);
            applyStimulus(2'b00, 1'b0, 4'd0, 2'b01, 1'b1);
            tick();
        end
        checkOutput("t6_last_data", s_wdata, 32'h110);
        applyStimulus(2'b00, 1'b0, 4'd0, 2'b00, 1'b1);
        tick();
        checkOutput("t6_idle", busy, 1'b0);
        checkOutput("t6_beats", hs_cnt - base, 16);
        checkOutput("t6_last_pos", last_at - base, 16);
        applyStimulus(2'b10, 1'b1, 4'd0, 2'b00, 1'b1);
        tick();
        checkOutput("t6_new_sel", m_wready, 2'b10);
        m_wdata = {32'h0BADF00D, 32'h0};
        applyStimulus(2'b00, 1'b0, 4'd0, 2'b10, 1'b1);
        tick();
        checkOutput("t6_new_data", s_wdata, 32'h0BADF00D);
        applyStimulus(2'b00, 1'b0, 4'd0, 2'b00, 1'b1);
        wait_idle(10);

        // Reset asserted for two cycles in the middle of an eight-beat burst.
        base = last_cnt;
        applyStimulus(2'b10, 1'b1, 4'd7, 2'b00, 1'b1);
        tick();
        for (int b = 0; b < 3; b++) begin
            m_wdata = {32'h500 + 32'(b), 32'h0};
            applyStimulus(2'b00, 1'b0, 4'd0, 2'b10, 1'b1);
            tick();
        end
        rst = 1'b1;
        tick();
        checkOutput("t1_wvalid", s_wvalid, 1'b0);
        checkOutput("t1_busy", busy, 1'b0);
        checkOutput("t1_ready", m_wready, 2'b00);
        checkOutput("t1_wlast", s_wlast, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("t1_no_last", last_cnt - base, 0);

        // Randomized traffic. Short bursts are more likely, starts sometimes
        // overlap a burst, and bad grants and resets appear now and then.
        for (int c = 0; c < 4000; c++) begin
            logic [NM-1:0] g;
            int            r;
            r = $urandom_range(0, 9);
            g = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
            m_wdata   = {$urandom(), $urandom()};
            grant     = g;
            start     = ($urandom_range(0, 5) == 0);
            burst_len = ($urandom_range(0, 3) == 0) ? BW'($urandom_range(0, 15))
                                                    : BW'($urandom_range(0, 3));
            m_wvalid  = NM'({($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
            s_wready  = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        applyStimulus(2'b00, 1'b0, 4'd0, 2'b00, 1'b1);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
